prog_loader: RTL and testbench

Serial program loader for the MiniAlu core. Receives an 8N1 UART byte stream and decodes a simple load frame. Assembles 28-bit instructions from it and writes them into the instruction memory through a write port. Holds the core in reset while a load is in progress, then releases it so execution restarts at address 0 with the new program.

---
 rtl/prog_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Serial program loader for the MiniAlu core. Receives 8N1 UART
//            bytes, decodes a load frame (SYNC, word count, 4 bytes per word,
//            little-endian) and writes 28-bit instructions into instruction
//            memory while holding the core in reset.
// Ports    : Clock         - system clock, rising edge
//            Reset         - asynchronous active-low reset
//            iRx           - UART receive line (idle high, asynchronous)
//            oWriteEnable  - one-cycle instruction memory write strobe
//            oWriteAddress - instruction memory write address
//            oInstruction  - 28-bit instruction word to write
//            oCpuReset     - active-high reset to the core
//            oLoadDone     - one-cycle pulse on successful frame completion
//            oFrameError   - sticky framing error flag
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_WIDTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iRx,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [27:0]           oInstruction,
  output logic                  oCpuReset,
  output logic                  oLoadDone,
  output logic                  oFrameError
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_COUNT = 2'd1;
  localparam logic [1:0] F_DATA  = 2'd2;
  localparam logic [1:0] F_DONE  = 2'd3;

  // Receiver
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  rx_state_q, rx_state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_valid_q, byte_valid_d;
  logic        rx_err_q, rx_err_d;

  // Frame decoder
  logic [1:0]            f_state_q, f_state_d;
  logic [7:0]            count_q, count_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [27:0]           instr_q, instr_d;
  logic                  we_q, we_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Start detection is edge based so that a low stop bit (framing error)
  // leaving the line low does not immediately retrigger a new byte.
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    rx_err_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = 16'd0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = 16'd0;
          bit_cnt_d  = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          rx_err_d     = ~rx_sync_q;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // The received byte is read straight from shift_q, which stays stable
  // until the next byte's first data sample.
  always_comb begin
    f_state_d = f_state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    word_d    = word_q;
    instr_d   = instr_q;
    cpu_rst_d = cpu_rst_q;
    err_d     = err_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    // Address advances the cycle after the write strobe.
    addr_d    = we_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
    if (rx_err_q) begin
      err_d = 1'b1;
      if (f_state_q == F_COUNT || f_state_q == F_DATA) begin
        f_state_d = F_IDLE;
      end
    end else begin
      case (f_state_q)
        F_IDLE: begin
          if (byte_valid_q && shift_q == SYNC_BYTE) begin
            cpu_rst_d = 1'b1;
            err_d     = 1'b0;
            f_state_d = F_COUNT;
          end
        end
        F_COUNT: begin
          if (byte_valid_q) begin
            if (shift_q == 8'd0) begin
              f_state_d = F_IDLE;
            end else begin
              count_d   = shift_q;
              addr_d    = '0;
              idx_d     = 2'd0;
              f_state_d = F_DATA;
            end
          end
        end
        F_DATA: begin
          if (byte_valid_q) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0: word_d[7:0]   = shift_q;
              2'd1: word_d[15:8]  = shift_q;
              2'd2: word_d[23:16] = shift_q;
              default: begin
                instr_d = {shift_q[3:0], word_q};
                we_d    = 1'b1;
                count_d = count_q - 8'd1;
                if (count_q == 8'd1) begin
                  f_state_d = F_DONE;
                end
              end
            endcase
          end
        end
        default: begin
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
          f_state_d = F_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= 16'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
      f_state_q    <= F_IDLE;
      count_q      <= 8'd0;
      idx_q        <= 2'd0;
      word_q       <= 24'd0;
      addr_q       <= '0;
      instr_q      <= 28'd0;
      we_q         <= 1'b0;
      cpu_rst_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_meta_q    <= iRx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      rx_err_q     <= rx_err_d;
      f_state_q    <= f_state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      we_q         <= we_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oInstruction  = instr_q;
  assign oCpuReset     = cpu_rst_q;
  assign oLoadDone     = done_q;
  assign oFrameError   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader. Two instances share the
//            UART line and reset: A (ADDR_WIDTH=16) and B (ADDR_WIDTH=2, for
//            address wrap). Frame vectors come from a table; framing error,
//            start glitch and mid-frame reset are hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic        Clock;
  logic        Reset;
  logic        iRx;

  logic        a_we, a_cr, a_done, a_err;
  logic [15:0] a_addr;
  logic [27:0] a_instr;
  logic        b_we, b_cr, b_done, b_err;
  logic [1:0]  b_addr;
  logic [27:0] b_instr;

  prog_loader #(.CLKS_PER_BIT(4), .ADDR_WIDTH(16), .SYNC_BYTE(8'hA5)) u_dut_a (
    .Clock(Clock), .Reset(Reset), .iRx(iRx),
    .oWriteEnable(a_we), .oWriteAddress(a_addr), .oInstruction(a_instr),
    .oCpuReset(a_cr), .oLoadDone(a_done), .oFrameError(a_err)
  );

  prog_loader #(.CLKS_PER_BIT(4), .ADDR_WIDTH(2), .SYNC_BYTE(8'hA5)) u_dut_b (
    .Clock(Clock), .Reset(Reset), .iRx(iRx),
    .oWriteEnable(b_we), .oWriteAddress(b_addr), .oInstruction(b_instr),
    .oCpuReset(b_cr), .oLoadDone(b_done), .oFrameError(b_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Output monitor, sampled on the falling edge.
  int          cyc = 0;
  int          na, nb, ndone, done_cyc, ncr_fall;
  logic        cr_prev = 1'b0;
  logic [15:0] wa_a [16];
  logic [27:0] wd_a [16];
  int          wcyc_a [16];
  logic        wcr_a [16];
  logic [15:0] wa_b [16];
  logic [27:0] wd_b [16];

  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (a_we) begin
      if (na < 16) begin
        wa_a[na] = a_addr; wd_a[na] = a_instr; wcyc_a[na] = cyc; wcr_a[na] = a_cr;
      end
      na = na + 1;
    end
    if (b_we) begin
      if (nb < 16) begin
        wa_b[nb] = {14'd0, b_addr}; wd_b[nb] = b_instr;
      end
      nb = nb + 1;
    end
    if (a_done) begin
      ndone = ndone + 1;
      done_cyc = cyc;
    end
    if (cr_prev && !a_cr) ncr_fall = ncr_fall + 1;
    cr_prev = a_cr;
  end

  task automatic clear_mon();
    na = 0; nb = 0; ndone = 0; done_cyc = 0; ncr_fall = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step off the edge before driving.
  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    iRx = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      iRx = b[i];
      tick(4);
    end
    iRx = stop;
    tick(4);
    iRx = 1'b1;
  endtask

  typedef struct {
    int               nbytes;
    logic [23:0][7:0] bytes;   // right-aligned: first byte is most significant
    int               nw;
    logic [4:0][15:0] wa;
    logic [4:0][27:0] wd;
    int               ndone;
    logic             cr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    for (int v = 0; v < 5; v++) begin
      vecs[v].wa = '0;
      vecs[v].wd = '0;
    end
    // Two-word load
    vecs[0].nbytes = 10; vecs[0].bytes = 192'hA5_02_78_56_34_12_EF_CD_AB_F9;
    vecs[0].nw = 2; vecs[0].ndone = 1; vecs[0].cr = 1'b0;
    vecs[0].wa[0] = 16'd0; vecs[0].wd[0] = 28'h2345678;
    vecs[0].wa[1] = 16'd1; vecs[0].wd[1] = 28'h9ABCDEF;
    // Junk byte ignored, then zero-length frame: core stays in reset
    vecs[1].nbytes = 4; vecs[1].bytes = 192'h3C_00_A5_00;
    vecs[1].nw = 0; vecs[1].ndone = 0; vecs[1].cr = 1'b1;
    // SYNC values inside the frame are plain data
    vecs[2].nbytes = 6; vecs[2].bytes = 192'hA5_01_A5_A5_A5_05;
    vecs[2].nw = 1; vecs[2].ndone = 1; vecs[2].cr = 1'b0;
    vecs[2].wa[0] = 16'd0; vecs[2].wd[0] = 28'h5A5A5A5;
    // Five words: wraps on the 2-bit instance, top nibble of byte 3 dropped
    vecs[3].nbytes = 22;
    vecs[3].bytes = 192'hA5_05_11_11_11_01_22_22_22_02_33_33_33_03_44_44_44_04_55_55_55_F5;
    vecs[3].nw = 5; vecs[3].ndone = 1; vecs[3].cr = 1'b0;
    vecs[3].wa[0] = 16'd0; vecs[3].wd[0] = 28'h1111111;
    vecs[3].wa[1] = 16'd1; vecs[3].wd[1] = 28'h2222222;
    vecs[3].wa[2] = 16'd2; vecs[3].wd[2] = 28'h3333333;
    vecs[3].wa[3] = 16'd3; vecs[3].wd[3] = 28'h4444444;
    vecs[3].wa[4] = 16'd4; vecs[3].wd[4] = 28'h5555555;
    // Leading zero byte in idle is ignored
    vecs[4].nbytes = 7; vecs[4].bytes = 192'h00_A5_01_67_45_23_81;
    vecs[4].nw = 1; vecs[4].ndone = 1; vecs[4].cr = 1'b0;
    vecs[4].wa[0] = 16'd0; vecs[4].wd[0] = 28'h1234567;

    Reset = 1'b0;
    iRx   = 1'b1;
    clear_mon();
    tick(3);
    chk("rst_we",    32'(a_we),    32'd0);
    chk("rst_addr",  32'(a_addr),  32'd0);
    chk("rst_instr", 32'(a_instr), 32'd0);
    chk("rst_cr",    32'(a_cr),    32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_err",   32'(a_err),   32'd0);
    Reset = 1'b1;
    tick(5);

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        send_byte(vecs[v].bytes[vecs[v].nbytes - 1 - i], 1'b1);
      end
      tick(20);
      chk($sformatf("v%0d_nwrites_a", v), 32'(na), 32'(vecs[v].nw));
      for (int k = 0; k < vecs[v].nw; k++) begin
        chk($sformatf("v%0d_addr_a%0d", v, k), 32'(wa_a[k]), 32'(vecs[v].wa[k]));
        chk($sformatf("v%0d_data_a%0d", v, k), 32'(wd_a[k]), 32'(vecs[v].wd[k]));
        chk($sformatf("v%0d_cr_at_wr%0d", v, k), 32'(wcr_a[k]), 32'd1);
        chk($sformatf("v%0d_addr_b%0d", v, k), 32'(wa_b[k]), 32'(vecs[v].wa[k][1:0]));
        chk($sformatf("v%0d_data_b%0d", v, k), 32'(wd_b[k]), 32'(vecs[v].wd[k]));
      end
      chk($sformatf("v%0d_nwrites_b", v), 32'(nb), 32'(vecs[v].nw));
      chk($sformatf("v%0d_ndone", v), 32'(ndone), 32'(vecs[v].ndone));
      chk($sformatf("v%0d_cr_falls", v), 32'(ncr_fall), 32'(vecs[v].ndone));
      if (ndone > 0 && na > 0 && na <= 16) begin
        chk($sformatf("v%0d_done_after_wr", v), 32'(done_cyc), 32'(wcyc_a[na-1] + 1));
      end
      chk($sformatf("v%0d_cr_final", v), 32'(a_cr), 32'(vecs[v].cr));
      chk($sformatf("v%0d_err_final", v), 32'(a_err), 32'd0);
    end

    // ---------------- framing error mid-word ----------------
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    tick(20);
    chk("ferr_err",    32'(a_err), 32'd1);
    chk("ferr_nwr",    32'(na),    32'd0);
    chk("ferr_cr",     32'(a_cr),  32'd1);
    // A full word's worth of bytes must not produce a write from idle.
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h07, 1'b1);
    tick(20);
    chk("ferr_idle_nwr", 32'(na),    32'd0);
    chk("ferr_sticky",   32'(a_err), 32'd1);
    send_byte(8'hA5, 1'b1);
    tick(20);
    chk("ferr_cleared",  32'(a_err), 32'd0);
    chk("ferr_cr_held",  32'(a_cr),  32'd1);
    send_byte(8'h00, 1'b1);
    tick(20);

    // ---------------- start-bit glitch ----------------
    clear_mon();
    iRx = 1'b0;
    tick(1);
    iRx = 1'b1;
    tick(60);
    chk("glitch_err", 32'(a_err), 32'd0);
    chk("glitch_nwr", 32'(na),    32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hBC, 1'b1);
    send_byte(8'h0A, 1'b1);
    tick(20);
    chk("glitch_load_nwr",  32'(na),      32'd1);
    chk("glitch_load_addr", 32'(wa_a[0]), 32'd0);
    chk("glitch_load_data", 32'(wd_a[0]), 32'h0ABCDEF0);
    chk("glitch_load_done", 32'(ndone),   32'd1);
    chk("glitch_load_cr",   32'(a_cr),    32'd0);

    // ---------------- reset mid-word ----------------
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(10);
    chk("mrst_cr_before", 32'(a_cr), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("mrst_we",    32'(a_we),    32'd0);
    chk("mrst_addr",  32'(a_addr),  32'd0);
    chk("mrst_instr", 32'(a_instr), 32'd0);
    chk("mrst_cr",    32'(a_cr),    32'd0);
    chk("mrst_done",  32'(a_done),  32'd0);
    chk("mrst_err",   32'(a_err),   32'd0);
    tick(3);
    Reset = 1'b1;
    tick(5);
    chk("mrst_no_partial_wr", 32'(na), 32'd0);
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'hF1, 1'b1);
    tick(20);
    chk("mrst_load_nwr",  32'(na),      32'd1);
    chk("mrst_load_addr", 32'(wa_a[0]), 32'd0);
    chk("mrst_load_data", 32'(wd_a[0]), 32'h01223344);
    chk("mrst_load_done", 32'(ndone),   32'd1);
    chk("mrst_load_cr",   32'(a_cr),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
